// File: rtl/axis_frame_fragmenter.sv
// AXI-Stream frame fragmenter: buffers up to FRAG_WORDS words per fragment, then emits header + payload.
// Optional build macro FRAG_TRAILER_EN appends an XOR checksum trailer word to every fragment.
module axis_frame_fragmenter #(
    parameter int FRAG_WORDS = 256,
    parameter int BUF_AW     = $clog2(FRAG_WORDS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        err_frag_ovf,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    // Handshakes: a beat transfers on a rising edge where tvalid && tready are both high;
    // the master holds tdata/tlast stable while tvalid=1 and tready=0.

    localparam int CW = BUF_AW + 1;
    localparam logic [CW-1:0] FRAG_MAX = CW'(FRAG_WORDS);

`ifdef FRAG_TRAILER_EN
    typedef enum logic [1:0] {FILL = 2'd0, HDR = 2'd1, PAY = 2'd2, TRL = 2'd3} state_t;
`else
    typedef enum logic [1:0] {FILL = 2'd0, HDR = 2'd1, PAY = 2'd2} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [CW-1:0] len_q, len_d;
    logic          last_q, last_d;
    logic [11:0]   seq_q, seq_d;
    logic [7:0]    idx_q, idx_d;
    logic          err_q, err_d;
    logic [31:0]   tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic          buf_we;
    logic          frag_done;
    logic [CW-1:0] wr_inc, rd_inc;
    logic [31:0]   hdr_word, rd_word;
    logic [31:0]   buf_mem [FRAG_WORDS];
`ifdef FRAG_TRAILER_EN
    logic [31:0]   csum_q, csum_d;
`endif

    // tkeep is ignored: every input beat is a full word.
    logic unused_tkeep;
    assign unused_tkeep = ^s_axis_tkeep;

    assign wr_inc   = wr_cnt_q + CW'(1);
    assign rd_inc   = rd_cnt_q + CW'(1);
    assign hdr_word = {seq_q, idx_q, last_q, 11'(len_q)};
    assign rd_word  = buf_mem[rd_cnt_q[BUF_AW-1:0]];

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        len_d     = len_q;
        last_d    = last_q;
        seq_d     = seq_q;
        idx_d     = idx_q;
        err_d     = err_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        buf_we    = 1'b0;
        frag_done = 1'b0;
`ifdef FRAG_TRAILER_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            FILL: begin
                if (s_axis_tvalid) begin
                    buf_we   = 1'b1;
                    wr_cnt_d = wr_inc;
`ifdef FRAG_TRAILER_EN
                    csum_d   = csum_q ^ s_axis_tdata;
`endif
                    if (wr_inc == FRAG_MAX || s_axis_tlast) begin
                        state_d  = HDR;
                        len_d    = wr_inc;
                        last_d   = s_axis_tlast;
                        rd_cnt_d = '0;
                        tdata_d  = {seq_q, idx_q, s_axis_tlast, 11'(wr_inc)};
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b0;
                    end
                end
            end
            HDR: begin
                // Payload word 0 loads on the header handshake so there is no bubble.
                if (m_axis_tready) begin
                    state_d  = PAY;
                    tdata_d  = rd_word;
                    rd_cnt_d = rd_inc;
`ifdef FRAG_TRAILER_EN
                    tlast_d  = 1'b0;
`else
                    tlast_d  = (len_q == CW'(1));
`endif
                end
            end
            PAY: begin
                if (m_axis_tready) begin
                    if (rd_cnt_q == len_q) begin
`ifdef FRAG_TRAILER_EN
                        state_d = TRL;
                        tdata_d = hdr_word ^ csum_q;
                        tlast_d = 1'b1;
`else
                        frag_done = 1'b1;
`endif
                    end else begin
                        tdata_d  = rd_word;
                        rd_cnt_d = rd_inc;
`ifdef FRAG_TRAILER_EN
                        tlast_d  = 1'b0;
`else
                        tlast_d  = (rd_inc == len_q);
`endif
                    end
                end
            end
`ifdef FRAG_TRAILER_EN
            TRL: begin
                if (m_axis_tready) frag_done = 1'b1;
            end
`endif
            default: state_d = FILL;
        endcase

        if (frag_done) begin
            state_d  = FILL;
            wr_cnt_d = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
`ifdef FRAG_TRAILER_EN
            csum_d   = '0;
`endif
            if (last_q) begin
                seq_d = seq_q + 12'd1;
                idx_d = '0;
            end else begin
                idx_d = idx_q + 8'd1;
                if (idx_q == 8'hFF) err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= FILL;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            len_q    <= '0;
            last_q   <= 1'b0;
            seq_q    <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
`ifdef FRAG_TRAILER_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            len_q    <= len_d;
            last_q   <= last_d;
            seq_q    <= seq_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
`ifdef FRAG_TRAILER_EN
            csum_q   <= csum_d;
`endif
        end
    end

    // Buffer contents need no reset; wr_cnt alone decides what is valid.
    always_ff @(posedge clk) begin
        if (buf_we) buf_mem[wr_cnt_q[BUF_AW-1:0]] <= s_axis_tdata;
    end

    assign s_axis_tready = (state_q == FILL);
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = 4'hF;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign err_frag_ovf  = err_q;
    assign busy          = !((state_q == FILL) && (wr_cnt_q == '0));
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_axis_frame_fragmenter.sv
// Directed bench for axis_frame_fragmenter with FRAG_WORDS=4; trailer expectations follow FRAG_TRAILER_EN.
module tb_axis_frame_fragmenter;

    localparam int FW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        err_frag_ovf;
    logic        busy;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];
    logic [31:0] in_q[$];
    logic [31:0] acc;

    axis_frame_fragmenter #(.FRAG_WORDS(FW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .err_frag_ovf(err_frag_ovf), .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_hdr(input logic [31:0] h);
        acc = h;
        exp_q.push_back({1'b0, h});
    endtask

    task automatic push_pay(input logic [31:0] w, input logic fin);
        logic tl;
`ifdef FRAG_TRAILER_EN
        tl = 1'b0;
`else
        tl = fin;
`endif
        acc = acc ^ w;
        exp_q.push_back({tl, w});
    endtask

    task automatic end_frag();
`ifdef FRAG_TRAILER_EN
        exp_q.push_back({1'b1, acc});
`endif
    endtask

    task automatic send_frame();
        int guard = 0;
        while (in_q.size() > 0 && guard < 6000) begin
            @(negedge clk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = in_q[0];
            s_axis_tlast  = (in_q.size() == 1);
            if (s_axis_tready) void'(in_q.pop_front());
            guard++;
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check("send_done", 32'(in_q.size()), 32'd0);
        in_q.delete();
    endtask

    task automatic collect(input bit rnd, input bit full);
        int          guard = 0;
        bit          prev_stall = 1'b0;
        logic [31:0] pd = '0;
        logic        pl = 1'b0;
        logic [32:0] e;
        while (exp_q.size() > 0 && guard < 6000) begin
            @(negedge clk);
            guard++;
            if (prev_stall) begin
                check("hold_data", m_axis_tdata, pd);
                check("hold_last", 32'(m_axis_tlast), 32'(pl));
            end
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_axis_tvalid) begin
                check("s_ready_low", 32'(s_axis_tready), 32'd0);
                check("busy_out", 32'(busy), 32'd1);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                e = exp_q.pop_front();
                check("out_data", m_axis_tdata, e[31:0]);
                check("out_last", 32'(m_axis_tlast), 32'(e[32]));
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata;
            pl = m_axis_tlast;
        end
        check("collect_done", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        if (full) begin
            @(negedge clk);
            check("end_tvalid", 32'(m_axis_tvalid), 32'd0);
            check("end_s_ready", 32'(s_axis_tready), 32'd1);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = 4'h0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset values
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_tdata", m_axis_tdata, 32'd0);
        check("rst_tkeep", 32'(m_axis_tkeep), 32'hF);
        check("rst_s_ready", 32'(s_axis_tready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_frag_ovf), 32'd0);

        // 3-word frame, single fragment, seq 0
        in_q = '{32'h11, 32'h22, 32'h33};
        push_hdr(32'h0000_0803);
        push_pay(32'h11, 1'b0); push_pay(32'h22, 1'b0); push_pay(32'h33, 1'b1); end_frag();
        fork send_frame(); collect(1'b0, 1'b1); join
        check("idle_busy", 32'(busy), 32'd0);

        // 10-word frame, seq 1: fragments of 4,4,2
        for (int i = 0; i < 10; i++) in_q.push_back(32'hA0 + 32'(i));
        push_hdr(32'h0010_0004);
        for (int i = 0; i < 4; i++) push_pay(32'hA0 + 32'(i), i == 3);
        end_frag();
        push_hdr(32'h0010_1004);
        for (int i = 4; i < 8; i++) push_pay(32'hA0 + 32'(i), i == 7);
        end_frag();
        push_hdr(32'h0010_2802);
        push_pay(32'hA8, 1'b0); push_pay(32'hA9, 1'b1); end_frag();
        fork send_frame(); collect(1'b0, 1'b1); join

        // Exactly 4-word frame (seq 2), then a 1-word frame (seq 3)
        in_q = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        push_hdr(32'h0020_0804);
        for (int i = 0; i < 4; i++) push_pay(32'hB0 + 32'(i), i == 3);
        end_frag();
        fork send_frame(); collect(1'b0, 1'b1); join
        in_q = '{32'hC0};
        push_hdr(32'h0030_0801);
        push_pay(32'hC0, 1'b1); end_frag();
        fork send_frame(); collect(1'b0, 1'b1); join

        // 10-word frame (seq 4) with random downstream stalls
        for (int i = 0; i < 10; i++) in_q.push_back(32'hA0 + 32'(i));
        push_hdr(32'h0040_0004);
        for (int i = 0; i < 4; i++) push_pay(32'hA0 + 32'(i), i == 3);
        end_frag();
        push_hdr(32'h0040_1004);
        for (int i = 4; i < 8; i++) push_pay(32'hA0 + 32'(i), i == 7);
        end_frag();
        push_hdr(32'h0040_2802);
        push_pay(32'hA8, 1'b0); push_pay(32'hA9, 1'b1); end_frag();
        fork send_frame(); collect(1'b1, 1'b1); join

        // Reset while payload word 2 of 4 is on the bus (seq 5)
        in_q = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
        push_hdr(32'h0050_0804);
        push_pay(32'hD0, 1'b0); push_pay(32'hD1, 1'b0);
        fork send_frame(); collect(1'b0, 1'b0); join
        @(negedge clk);
        check("pay2_valid", 32'(m_axis_tvalid), 32'd1);
        check("pay2_data", m_axis_tdata, 32'hD2);
        rst_n = 1'b0;
        m_axis_tready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("mid_rst_s_ready", 32'(s_axis_tready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);

        // 2-word frame after reset: seq 0, idx 0
        in_q = '{32'hE0, 32'hE1};
        push_hdr(32'h0000_0802);
        push_pay(32'hE0, 1'b0); push_pay(32'hE1, 1'b1); end_frag();
        fork send_frame(); collect(1'b0, 1'b1); join

        // Frame 0x1,0x2 (seq 1); trailer build expects 0x00100801 after the payload
        in_q = '{32'h1, 32'h2};
        push_hdr(32'h0010_0802);
        push_pay(32'h1, 1'b0); push_pay(32'h2, 1'b1); end_frag();
        fork send_frame(); collect(1'b0, 1'b1); join
        check("pre_ovf_err", 32'(err_frag_ovf), 32'd0);

        // 257 fragments in one frame (seq 2): fragment index wraps 255->0
        for (int k = 0; k <= 256; k++) begin
            push_hdr({12'd2, 8'(k), (k == 256), 11'd4});
            for (int j = 0; j < 4; j++) begin
                in_q.push_back(32'h1000 + 32'(4 * k + j));
                push_pay(32'h1000 + 32'(4 * k + j), j == 3);
            end
            end_frag();
        end
        fork send_frame(); collect(1'b0, 1'b1); join
        check("ovf_err_set", 32'(err_frag_ovf), 32'd1);
        @(negedge clk);
        check("ovf_err_sticky", 32'(err_frag_ovf), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("ovf_err_cleared", 32'(err_frag_ovf), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
